// File: rtl/core_ctrl_pkg.sv
// Shared types and constants for the boot/test sequencer.
package core_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_TEST = 3'd3,
    ST_HALT = 3'd4
  } state_e;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_LOAD_OVF = 2'b01;
  localparam logic [1:0] CAUSE_UNCORR   = 2'b10;
  localparam logic [1:0] CAUSE_FAULT    = 2'b11;

  // Instruction memory is word-addressed internally, byte-addressed on the port.
  localparam int unsigned IMEM_STRIDE = 4;

  // 8-bit increment that sticks at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/test_window_timer.sv
// Period/window timer: TEST_PERIOD run cycles, then a TEST_WINDOW-cycle
// self-test window, repeating while run_en is high. clear parks it at the
// start of a period.
module test_window_timer #(
  parameter int TEST_PERIOD = 1024,
  parameter int TEST_WINDOW = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic run_en,
  input  logic clear,
  output logic window_start,
  output logic in_window,
  output logic window_end
);

  localparam int PW = $clog2(TEST_PERIOD);
  localparam int WW = $clog2(TEST_WINDOW + 1);

  logic [PW-1:0] period_q, period_d;
  logic [WW-1:0] win_q, win_d;
  logic          in_win_q, in_win_d;

  assign in_window    = in_win_q;
  // Last run cycle of a period: the window opens on the next cycle.
  assign window_start = run_en & ~in_win_q & (period_q == PW'(TEST_PERIOD - 1));
  // Last cycle inside the window.
  assign window_end   = run_en & in_win_q & (win_q == WW'(TEST_WINDOW - 1));

  // Next-state for the period and window counters.
  always_comb begin
    period_d = period_q;
    win_d    = win_q;
    in_win_d = in_win_q;
    if (clear) begin
      period_d = '0;
      win_d    = '0;
      in_win_d = 1'b0;
    end else if (run_en) begin
      if (window_start) begin
        in_win_d = 1'b1;
        win_d    = '0;
        period_d = '0;
      end else if (window_end) begin
        in_win_d = 1'b0;
        win_d    = '0;
        period_d = '0;
      end else if (in_win_q) begin
        win_d = win_q + 1'b1;
      end else begin
        period_d = period_q + 1'b1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_q <= '0;
      win_q    <= '0;
      in_win_q <= 1'b0;
    end else begin
      period_q <= period_d;
      win_q    <= win_d;
      in_win_q <= in_win_d;
    end
  end

endmodule

// File: rtl/boot_test_scheduler.sv
// Boot/test sequencer: loads the program image, releases the core, runs
// periodic self-test windows and halts the core on serious faults.
//
// Loader handshake: a word transfers on a cycle where ld_valid and ld_ready
// are both high; ld_ready is high exactly while in LOAD, ld_data/ld_last are
// sampled only on a transfer, and ld_valid is ignored in every other state.
module boot_test_scheduler
  import core_ctrl_pkg::*;
#(
  parameter int IMEM_DEPTH   = 64,
  parameter int TEST_PERIOD  = 1024,
  parameter int TEST_WINDOW  = 16,
  parameter int FAULT_THRESH = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        imem_we,
  output logic [31:0] imem_waddr,
  output logic [31:0] imem_wdata,
  output logic        loader_done,
  output logic        test_en,
  input  logic        hardware_fault_flag,
  input  logic        mux_error_flag,
  input  logic        s_err_imem,
  input  logic        s_err_dmem,
  input  logic        d_err_imem,
  input  logic        d_err_dmem,
  input  logic        restart,
  output logic [7:0]  fault_count,
  output logic [7:0]  ce_count,
  output logic        core_halt,
  output logic [1:0]  halt_cause,
  output logic [2:0]  dbg_state
);

  state_e      state_q, state_d;
  logic [31:0] idx_q, idx_d;
  logic [7:0]  fault_count_q, fault_count_d;
  logic [7:0]  ce_count_q, ce_count_d;
  logic [1:0]  halt_cause_q, halt_cause_d;
  logic        win_fault_q, win_fault_d;
  logic        ld_ready_q, imem_we_q, loader_done_q, test_en_q, core_halt_q;
  logic [31:0] imem_waddr_q, imem_wdata_q;

  logic       run_active, accept, win_faulty;
  logic       window_start, in_window, window_end;
  logic [7:0] fault_inc;

  assign run_active = (state_q == ST_RUN) || (state_q == ST_TEST);
  assign accept     = ld_valid & ld_ready_q;
  // Window is faulty if any flag was seen so far in it, including this cycle.
  assign win_faulty = win_fault_q | (in_window & (hardware_fault_flag | mux_error_flag));
  assign fault_inc  = sat_inc8(fault_count_q);

  test_window_timer #(
    .TEST_PERIOD(TEST_PERIOD),
    .TEST_WINDOW(TEST_WINDOW)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .run_en      (run_active),
    .clear       (~run_active),
    .window_start(window_start),
    .in_window   (in_window),
    .window_end  (window_end)
  );

  // FSM next state, load index, fault/error counters and halt cause.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    fault_count_d = fault_count_q;
    ce_count_d    = ce_count_q;
    halt_cause_d  = halt_cause_q;
    win_fault_d   = win_fault_q;
    case (state_q)
      ST_IDLE: begin
        idx_d       = '0;
        win_fault_d = 1'b0;
        state_d     = ST_LOAD;
      end
      ST_LOAD: begin
        if (accept) begin
          idx_d = idx_q + 32'd1;
          if (ld_last) begin
            state_d = ST_RUN;
          end else if (idx_q == 32'(IMEM_DEPTH - 1)) begin
            state_d      = ST_HALT;
            halt_cause_d = CAUSE_LOAD_OVF;
          end
        end
      end
      ST_RUN, ST_TEST: begin
        if (s_err_imem | s_err_dmem) ce_count_d = sat_inc8(ce_count_q);
        win_fault_d = win_faulty;
        if ((state_q == ST_TEST) && window_end) begin
          win_fault_d = 1'b0;
          state_d     = ST_RUN;
          if (win_faulty) begin
            fault_count_d = fault_inc;
            if (fault_inc >= 8'(FAULT_THRESH)) begin
              state_d      = ST_HALT;
              halt_cause_d = CAUSE_FAULT;
            end
          end
        end else if ((state_q == ST_RUN) && window_start) begin
          state_d = ST_TEST;
        end
        // Uncorrectable ECC outranks every other event in the same cycle.
        if (d_err_imem | d_err_dmem) begin
          state_d      = ST_HALT;
          halt_cause_d = CAUSE_UNCORR;
        end
      end
      ST_HALT: begin
        if (restart) begin
          state_d       = ST_IDLE;
          fault_count_d = '0;
          ce_count_d    = '0;
          halt_cause_d  = CAUSE_NONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs (outputs decode the next state).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      fault_count_q <= '0;
      ce_count_q    <= '0;
      halt_cause_q  <= CAUSE_NONE;
      win_fault_q   <= 1'b0;
      ld_ready_q    <= 1'b0;
      imem_we_q     <= 1'b0;
      imem_waddr_q  <= '0;
      imem_wdata_q  <= '0;
      loader_done_q <= 1'b0;
      test_en_q     <= 1'b0;
      core_halt_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      fault_count_q <= fault_count_d;
      ce_count_q    <= ce_count_d;
      halt_cause_q  <= halt_cause_d;
      win_fault_q   <= win_fault_d;
      ld_ready_q    <= (state_d == ST_LOAD);
      imem_we_q     <= accept;
      if (accept) begin
        imem_waddr_q <= idx_q * 32'(IMEM_STRIDE);
        imem_wdata_q <= ld_data;
      end
      // Core enable starts one cycle after the last image write.
      loader_done_q <= run_active && ((state_d == ST_RUN) || (state_d == ST_TEST));
      test_en_q     <= (state_d == ST_TEST);
      core_halt_q   <= (state_d == ST_HALT);
    end
  end

  assign ld_ready    = ld_ready_q;
  assign imem_we     = imem_we_q;
  assign imem_waddr  = imem_waddr_q;
  assign imem_wdata  = imem_wdata_q;
  assign loader_done = loader_done_q;
  assign test_en     = test_en_q;
  assign fault_count = fault_count_q;
  assign ce_count    = ce_count_q;
  assign core_halt   = core_halt_q;
  assign halt_cause  = halt_cause_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_boot_test_scheduler.sv
// Bench for boot_test_scheduler: image loads with random gaps, randomized
// run phases checked against a window/period model, overflow, restart and reset.
module tb_boot_test_scheduler;

  localparam int DEPTH  = 4;
  localparam int PERIOD = 8;
  localparam int WINDOW = 2;
  localparam int THRESH = 3;
  localparam int NRUN   = 80;
  localparam int BIG    = 100000;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        ld_valid = 1'b0, ld_last = 1'b0;
  logic [31:0] ld_data = '0;
  logic        hw_f = 1'b0, mux_f = 1'b0, se_i = 1'b0, se_d = 1'b0, de_i = 1'b0, de_d = 1'b0;
  logic        restart = 1'b0;
  logic        ld_ready, imem_we, loader_done, test_en, core_halt;
  logic [31:0] imem_waddr, imem_wdata;
  logic [7:0]  fault_count, ce_count;
  logic [1:0]  halt_cause;
  logic [2:0]  dbg_state;

  boot_test_scheduler #(
    .IMEM_DEPTH(DEPTH), .TEST_PERIOD(PERIOD), .TEST_WINDOW(WINDOW), .FAULT_THRESH(THRESH)
  ) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .loader_done(loader_done), .test_en(test_en),
    .hardware_fault_flag(hw_f), .mux_error_flag(mux_f),
    .s_err_imem(se_i), .s_err_dmem(se_d), .d_err_imem(de_i), .d_err_dmem(de_d),
    .restart(restart), .fault_count(fault_count), .ce_count(ce_count),
    .core_halt(core_halt), .halt_cause(halt_cause), .dbg_state(dbg_state)
  );

  // scoreboard
  logic [63:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h state=%0d t=%0t", tag, got, exp, dbg_state, $time);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ld_valid = 1'b0; ld_last = 1'b0;
    hw_f = 1'b0; mux_f = 1'b0; se_i = 1'b0; se_d = 1'b0; de_i = 1'b0; de_d = 1'b0;
    restart = 1'b0;
  endtask

  task automatic check_all_zero(input string tag, input bit with_bus);
    check_eq({tag, "_ld_ready"}, ld_ready, 0);
    check_eq({tag, "_imem_we"}, imem_we, 0);
    check_eq({tag, "_loader_done"}, loader_done, 0);
    check_eq({tag, "_test_en"}, test_en, 0);
    check_eq({tag, "_fault_count"}, fault_count, 0);
    check_eq({tag, "_ce_count"}, ce_count, 0);
    check_eq({tag, "_core_halt"}, core_halt, 0);
    check_eq({tag, "_halt_cause"}, halt_cause, 0);
    if (with_bus) begin
      check_eq({tag, "_waddr"}, imem_waddr, 0);
      check_eq({tag, "_wdata"}, imem_wdata, 0);
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    repeat (2) begin
      check_all_zero("reset", 1'b1);
      step();
    end
    check_all_zero("reset", 1'b1);
    rst = 1'b0;
  endtask

  // Called in the IDLE cycle. Streams up to nwords words with random gaps;
  // returns early once stop_at words are written (load still open).
  task automatic load_image(input int nwords, input bit use_last, input int stop_at);
    int sent = 0;
    int guard = 0;
    bit open = 1'b1;
    bit pend = 1'b0;
    bit ovf = 1'b0;
    logic [31:0] d;
    logic [31:0] a;
    logic [63:0] e;
    check_all_zero("idle", 1'b0);
    idle_inputs();
    step();
    while ((open && sent < stop_at) || pend) begin
      if (guard > 300) begin
        check_eq("load_timeout", 1, 0);
        break;
      end
      guard++;
      check_eq("ld_ready", ld_ready, open);
      check_eq("imem_we", imem_we, pend);
      check_eq("loader_done_load", loader_done, 0);
      check_eq("test_en_load", test_en, 0);
      check_eq("core_halt_load", core_halt, ovf && !open);
      check_eq("halt_cause_load", halt_cause, (ovf && !open) ? 1 : 0);
      if (imem_we) begin
        if (exp_q.size() == 0) check_eq("imem_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          check_eq("imem_waddr", imem_waddr, e[63:32]);
          check_eq("imem_wdata", imem_wdata, e[31:0]);
        end
      end
      d = $urandom;
      ld_data  = d;
      ld_valid = (sent < nwords && sent < stop_at) ? ($urandom_range(0, 3) != 0) : 1'b0;
      ld_last  = use_last && (sent == nwords - 1);
      pend = ld_valid && open;
      if (pend) begin
        a = 32'(sent * 4);
        exp_q.push_back({a, d});
        sent++;
        if (ld_last) open = 1'b0;
        else if (sent == DEPTH) begin
          open = 1'b0;
          ovf  = 1'b1;
        end
      end
      step();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    check_eq("exp_q_empty", exp_q.size(), 0);
  endtask

  // Drive restart in the current (HALT) cycle; returns in the IDLE cycle.
  task automatic restart_core();
    check_eq("halt_before_restart", core_halt, 1);
    restart = 1'b1;
    step();
    restart = 1'b0;
  endtask

  // Run phase starting one cycle after the final load write (run cycle n=1).
  // mode 0: random noise; 1: faults in 3 windows; 2: d_err in RUN;
  // 3: faults in 3 windows with d_err on the third window's last cycle.
  task automatic run_phase(input int mode, output bit halted);
    bit hw[NRUN], mx[NRUN], sei[NRUN], sed[NRUN], dei[NRUN], ded[NRUN], rs[NRUN];
    int wend[$];
    int hd, hthr, h, cause, cnt, fc, ce, picked, w3, idx, e;
    bit hn;
    for (int n = 0; n < NRUN; n++) begin
      hw[n] = 0; mx[n] = 0; sei[n] = 0; sed[n] = 0; dei[n] = 0; ded[n] = 0; rs[n] = 0;
    end
    w3 = 0;
    for (int n = 1; n < NRUN; n++) begin
      sei[n] = ($urandom_range(0, 5) == 0);
      sed[n] = ($urandom_range(0, 5) == 0);
      rs[n]  = ($urandom_range(0, 9) == 0);
      if (mode == 0 || mode == 2) begin
        hw[n] = ($urandom_range(0, 11) == 0);
        mx[n] = ($urandom_range(0, 11) == 0);
      end else if ((n % 10) < 8) begin
        hw[n] = ($urandom_range(0, 4) == 0);
        mx[n] = ($urandom_range(0, 4) == 0);
      end
    end
    if (mode == 1 || mode == 3) begin
      picked = 0;
      for (int w = 0; w < 6; w++) begin
        if (picked < 3 && ($urandom_range(0, 1) == 1 || (6 - w) <= (3 - picked))) begin
          idx = 10 * w + 8 + int'($urandom_range(0, 1));
          if ($urandom_range(0, 1) == 1) hw[idx] = 1; else mx[idx] = 1;
          picked++;
          w3 = w;
        end
      end
      if (mode == 3) begin
        if ($urandom_range(0, 1) == 1) ded[10 * w3 + 9] = 1; else dei[10 * w3 + 9] = 1;
      end
    end
    if (mode == 2) ded[$urandom_range(1, NRUN - 15)] = 1;

    // Reference model: run cycles are numbered from the first RUN cycle (n=0);
    // window w occupies n=10w+8..10w+9, its result lands on the next cycle.
    hd = BIG;
    for (int n = 1; n < NRUN; n++)
      if (hd == BIG && (dei[n] || ded[n])) hd = n + 1;
    cnt = 0;
    hthr = BIG;
    for (int w = 0; 10 * w + 9 < NRUN; w++) begin
      e = 10 * w + 9;
      if (e >= hd) break;
      if (hw[e - 1] || mx[e - 1] || hw[e] || mx[e]) begin
        cnt++;
        wend.push_back(e);
        if (cnt >= THRESH) begin
          hthr = e + 1;
          break;
        end
      end
    end
    h = (hd < hthr) ? hd : hthr;
    cause = (h == BIG) ? 0 : ((hd <= hthr) ? 2 : 3);
    for (int n = 0; n < NRUN; n++) if (n >= h) rs[n] = 0;

    for (int n = 1; n < NRUN; n++) begin
      hn = (n >= h);
      fc = 0;
      foreach (wend[i]) if (wend[i] < n) fc++;
      ce = 0;
      for (int m = 0; m < n && m < h; m++) if (sei[m] || sed[m]) ce++;
      check_eq("loader_done", loader_done, !hn);
      check_eq("test_en", test_en, !hn && ((n % 10) >= PERIOD));
      check_eq("core_halt", core_halt, hn);
      check_eq("fault_count", fault_count, fc);
      check_eq("ce_count", ce_count, ce);
      check_eq("halt_cause", halt_cause, hn ? cause : 0);
      check_eq("ld_ready_run", ld_ready, 0);
      check_eq("imem_we_run", imem_we, 0);
      hw_f = hw[n]; mux_f = mx[n]; se_i = sei[n]; se_d = sed[n];
      de_i = dei[n]; de_d = ded[n]; restart = rs[n];
      ld_valid = ($urandom_range(0, 3) == 0);
      ld_data  = $urandom;
      step();
    end
    idle_inputs();
    halted = (h <= NRUN);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    bit halted;
    idle_inputs();
    #1;

    // basic 3-word load, then periodic windows
    do_reset();
    load_image(3, 1'b1, 99);
    run_phase(0, halted);

    // fault threshold, then d_err, then coincident d_err/threshold, via restart
    do_reset();
    load_image($urandom_range(1, DEPTH), 1'b1, 99);
    run_phase(1, halted);
    check_eq("thresh_halted", halted, 1);
    if (halted) restart_core(); else do_reset();
    load_image(2, 1'b1, 99);
    run_phase(2, halted);
    check_eq("derr_halted", halted, 1);
    if (halted) restart_core(); else do_reset();
    load_image(DEPTH, 1'b1, 99);
    run_phase(3, halted);
    check_eq("coincident_halted", halted, 1);

    // image overflow: DEPTH+1 words without ld_last
    do_reset();
    load_image(DEPTH + 1, 1'b0, 99);
    for (int k = 0; k < 4; k++) begin
      check_eq("ovf_core_halt", core_halt, 1);
      check_eq("ovf_halt_cause", halt_cause, 1);
      check_eq("ovf_ld_ready", ld_ready, 0);
      check_eq("ovf_imem_we", imem_we, 0);
      check_eq("ovf_loader_done", loader_done, 0);
      ld_valid = 1'b1;
      ld_data  = $urandom;
      step();
    end
    ld_valid = 1'b0;
    restart_core();
    load_image(1, 1'b1, 99);
    run_phase(0, halted);

    // reset in the middle of a load, then a fresh single-word image
    do_reset();
    load_image(4, 1'b1, 2);
    do_reset();
    load_image(1, 1'b1, 99);
    run_phase($urandom_range(0, 3), halted);

    // random mix
    repeat (4) begin
      do_reset();
      load_image($urandom_range(1, DEPTH), 1'b1, 99);
      run_phase($urandom_range(0, 3), halted);
      if (halted) begin
        restart_core();
        load_image($urandom_range(1, DEPTH), 1'b1, 99);
        run_phase(0, halted);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
